// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   pc_sel_e        : next-PC source chosen by the priority encoder
//   DEF_PC_WIDTH    : default PC width in bits
//   DEF_RESET_VECTOR: default PC value loaded at reset
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  localparam int DEF_PC_WIDTH     = 6;
  localparam int DEF_RESET_VECTOR = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   push_i, push_data_i : push a return address (overwrites oldest when full)
//   pop_i            : pop the top entry (no pointer change when empty)
//   top_o            : most recently pushed entry still held
//   empty_o, full_o  : occupancy from the entry count
//   overflow_o       : sticky, a push happened while full
//   underflow_o      : sticky, a pop happened while empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  input  logic                pop_i,
  output logic [PC_WIDTH-1:0] top_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  // sp_q is the next write slot; when full it also points at the oldest entry,
  // so a push in that state naturally overwrites the oldest address.
  logic [PTR_W-1:0]    sp_q;
  logic [PTR_W:0]      count_q;
  logic                overflow_q, underflow_q;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == DEPTH_C);
  assign top_o       = mem_q[sp_q - 1'b1];
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push_i) begin
      mem_q[sp_q] <= push_data_i;
      sp_q        <= sp_q + 1'b1;
      if (full_o) overflow_q <= 1'b1;
      else        count_q    <= count_q + 1'b1;
    end else if (pop_i) begin
      if (empty_o) begin
        underflow_q <= 1'b1;
      end else begin
        sp_q    <= sp_q - 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and computes the next PC.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : hold PC and RAS
//   branch_taken, branch_offset : PC-relative branch (signed word offset)
//   jump, call, jump_target     : absolute jump / call (call pushes PC+INCR)
//   ret             : pop RAS top into PC
//   PC, PC_next     : registered fetch address / value loaded at next edge
//   ras_empty, ras_full, ras_overflow, ras_underflow : RAS status
// Priority: stall > ret > call > jump > branch_taken > sequential.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int INCR         = 1,
  parameter int RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic                call,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_next,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_overflow,
  output logic                ras_underflow
);

  localparam logic [PC_WIDTH-1:0] INCR_C  = PC_WIDTH'(INCR);
  localparam logic [PC_WIDTH-1:0] RESET_C = PC_WIDTH'(RESET_VECTOR);

  pc_sel_e             sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push, ras_pop;

  assign pc_inc = pc_q + INCR_C;

  always_comb begin
    sel = SEL_SEQ;
    if      (stall)        sel = SEL_HOLD;
    else if (ret)          sel = SEL_RET;
    else if (call)         sel = SEL_CALL;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
  end

  // The offset is already PC_WIDTH wide, so modulo-2^PC_WIDTH addition
  // gives the sign-extended result directly.
  always_comb begin
    pc_d     = pc_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unique case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_SEQ:    pc_d = pc_inc;
      SEL_BRANCH: pc_d = pc_inc + branch_offset;
      SEL_JUMP:   pc_d = jump_target;
      SEL_CALL: begin
        pc_d     = jump_target;
        ras_push = 1'b1;
      end
      SEL_RET: begin
        // An empty pop falls through to sequential; the RAS flags underflow.
        ras_pop = 1'b1;
        pc_d    = ras_empty ? pc_inc : ras_top;
      end
      default:    pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_C;
    else     pc_q <= pc_d;
  end

  assign PC      = pc_q;
  assign PC_next = pc_d;

  pc_ras #(
    .PC_WIDTH (PC_WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ras_push),
    .push_data_i(pc_inc),
    .pop_i      (ras_pop),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .overflow_o (ras_overflow),
    .underflow_o(ras_underflow)
  );

endmodule
